// File: rtl/decode_pkg.sv
// Shared decode definitions: instruction field layout, opcode constants,
// FSM state type and the per-opcode classification helpers.
package decode_pkg;

  localparam int INSTR_W  = 16;
  localparam int OPC_W    = 5;
  localparam int FIELD_W  = 3;

  localparam int OPC_LSB  = 11;
  localparam int RDST_LSB = 8;
  localparam int RS1_LSB  = 5;
  localparam int RS2_LSB  = 2;

  localparam logic [OPC_W-1:0] OP_NOP = 5'b00000;
  localparam logic [OPC_W-1:0] OP_LDM = 5'b10000;
  localparam logic [OPC_W-1:0] OP_LDD = 5'b10001;
  localparam logic [OPC_W-1:0] OP_STD = 5'b10010;

  typedef enum logic {
    S_NORM = 1'b0,
    S_IMM  = 1'b1
  } state_t;

  typedef struct packed {
    logic [OPC_W-1:0]   opcode;
    logic [FIELD_W-1:0] rdst;
    logic [FIELD_W-1:0] rs1;
    logic [FIELD_W-1:0] rs2;
  } header_t;

  // Pull the opcode and register fields out of an instruction word
  function automatic header_t split_header(input logic [INSTR_W-1:0] word);
    header_t h;
    h.opcode = word[OPC_LSB  +: OPC_W];
    h.rdst   = word[RDST_LSB +: FIELD_W];
    h.rs1    = word[RS1_LSB  +: FIELD_W];
    h.rs2    = word[RS2_LSB  +: FIELD_W];
    return h;
  endfunction

  // Any opcode with the top bit set is followed by an immediate word
  function automatic logic is_two_word(input logic [OPC_W-1:0] op);
    return op[OPC_W-1];
  endfunction

  function automatic logic is_alu(input logic [OPC_W-1:0] op);
    return (op[OPC_W-1:OPC_W-2] == 2'b01);
  endfunction

  // Two-word opcodes that actually do something once their immediate arrives
  function automatic logic is_known_two_word(input logic [OPC_W-1:0] op);
    return (op == OP_LDM) || (op == OP_LDD) || (op == OP_STD);
  endfunction

  function automatic logic uses_rs1(input logic [OPC_W-1:0] op);
    return is_alu(op) || (op == OP_STD);
  endfunction

  function automatic logic uses_rs2(input logic [OPC_W-1:0] op);
    return is_alu(op);
  endfunction

  function automatic logic reg_write(input logic [OPC_W-1:0] op);
    return is_alu(op) || (op == OP_LDM) || (op == OP_LDD);
  endfunction

  function automatic logic mem_read(input logic [OPC_W-1:0] op);
    return (op == OP_LDD);
  endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// Register file for the decode stage: REG_N words, two combinational read
// ports that forward a same-cycle write, one synchronous write port and a
// synchronous active-low clear.
module reg_file
  import decode_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_N  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wrEn,
  input  logic [$clog2(REG_N)-1:0] i_wrAddr,
  input  logic [DATA_W-1:0]        i_wrData,
  input  logic [$clog2(REG_N)-1:0] i_rdAddr1,
  input  logic [$clog2(REG_N)-1:0] i_rdAddr2,
  output logic [DATA_W-1:0]        o_rdData1,
  output logic [DATA_W-1:0]        o_rdData2
);

  logic [DATA_W-1:0] r_regs [REG_N];

  // Clear every register in reset, otherwise commit the writeback port
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < REG_N; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_wrEn) begin
      r_regs[i_wrAddr] <= i_wrData;
    end
  end

  // Reads see a write landing this very cycle so WB needs no extra bypass
  always_comb begin
    o_rdData1 = r_regs[i_rdAddr1];
    o_rdData2 = r_regs[i_rdAddr2];
    if (i_wrEn && (i_wrAddr == i_rdAddr1)) begin
      o_rdData1 = i_wrData;
    end
    if (i_wrEn && (i_wrAddr == i_rdAddr2)) begin
      o_rdData2 = i_wrData;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: reads operands, joins two-word instructions with
// their immediate, stalls fetch on a load-use dependency and registers the
// decoded result towards execute.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W   = 32,
  parameter int REG_N  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [INSTR_W-1:0]       instruction,
  input  logic [PC_W-1:0]          pc_plus_one,
  input  logic                     flush,
  input  logic                     wb_en,
  input  logic [$clog2(REG_N)-1:0] wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     stall_fetch,
  output logic                     id_ex_valid,
  output logic [OPC_W-1:0]         id_ex_opcode,
  output logic [FIELD_W-1:0]       id_ex_rdst,
  output logic [FIELD_W-1:0]       id_ex_rs1_addr,
  output logic [FIELD_W-1:0]       id_ex_rs2_addr,
  output logic [DATA_W-1:0]        id_ex_rs1_data,
  output logic [DATA_W-1:0]        id_ex_rs2_data,
  output logic [DATA_W-1:0]        id_ex_imm,
  output logic [PC_W-1:0]          id_ex_pc_plus_one,
  output logic                     id_ex_mem_read,
  output logic                     id_ex_reg_write
);

  localparam int ADDR_W = $clog2(REG_N);

  state_t  r_state;
  state_t  w_nextState;
  header_t r_header;
  header_t w_nextHeader;
  header_t w_instrHdr;
  header_t w_issueHdr;

  logic [ADDR_W-1:0] w_rdAddr1;
  logic [ADDR_W-1:0] w_rdAddr2;
  logic [DATA_W-1:0] w_rdData1;
  logic [DATA_W-1:0] w_rdData2;
  logic              w_hazard;
  logic              w_startImm;
  logic              w_emit;

  logic               w_valid;
  logic [OPC_W-1:0]   w_opcode;
  logic [FIELD_W-1:0] w_rdst;
  logic [FIELD_W-1:0] w_rs1;
  logic [FIELD_W-1:0] w_rs2;
  logic [DATA_W-1:0]  w_rs1Data;
  logic [DATA_W-1:0]  w_rs2Data;
  logic [DATA_W-1:0]  w_imm;
  logic [PC_W-1:0]    w_pc;
  logic               w_memRead;
  logic               w_regWrite;

  logic               r_valid;
  logic [OPC_W-1:0]   r_opcode;
  logic [FIELD_W-1:0] r_rdst;
  logic [FIELD_W-1:0] r_rs1;
  logic [FIELD_W-1:0] r_rs2;
  logic [DATA_W-1:0]  r_rs1Data;
  logic [DATA_W-1:0]  r_rs2Data;
  logic [DATA_W-1:0]  r_imm;
  logic [PC_W-1:0]    r_pc;
  logic               r_memRead;
  logic               r_regWrite;

  assign w_instrHdr = split_header(instruction);

  // While the immediate is on the bus the operands belong to the latched header
  assign w_issueHdr = (r_state == S_IMM) ? r_header : w_instrHdr;
  assign w_rdAddr1  = ADDR_W'(w_issueHdr.rs1);
  assign w_rdAddr2  = ADDR_W'(w_issueHdr.rs2);

  reg_file #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N)
  ) u_regFile (
    .clk       (clk),
    .reset     (reset),
    .i_wrEn    (wb_en),
    .i_wrAddr  (wb_addr),
    .i_wrData  (wb_data),
    .i_rdAddr1 (w_rdAddr1),
    .i_rdAddr2 (w_rdAddr2),
    .o_rdData1 (w_rdData1),
    .o_rdData2 (w_rdData2)
  );

  // A load in EX whose destination feeds a source this instruction really uses
  always_comb begin
    w_hazard = 1'b0;
    if ((r_state == S_NORM) && r_valid && r_memRead) begin
      if (uses_rs1(w_instrHdr.opcode) && (r_rdst == w_instrHdr.rs1)) begin
        w_hazard = 1'b1;
      end
      if (uses_rs2(w_instrHdr.opcode) && (r_rdst == w_instrHdr.rs2)) begin
        w_hazard = 1'b1;
      end
    end
  end

  assign stall_fetch = reset && !flush && w_hazard;
  assign w_startImm  = (r_state == S_NORM) && !w_hazard && is_two_word(w_instrHdr.opcode);

  // State register for the header/immediate sequencing
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_NORM;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Move to S_IMM after a header, back to S_NORM after its immediate or a flush
  always_comb begin
    w_nextState = r_state;
    if (flush) begin
      w_nextState = S_NORM;
    end else begin
      case (r_state)
        S_NORM:  w_nextState = w_startImm ? S_IMM : S_NORM;
        S_IMM:   w_nextState = S_NORM;
        default: w_nextState = S_NORM;
      endcase
    end
  end

  // Decide what goes to execute this cycle; anything not issued is a zeroed bubble
  always_comb begin
    w_emit = 1'b0;
    w_imm  = '0;
    if (!flush) begin
      case (r_state)
        S_NORM: begin
          w_emit = !w_hazard && is_alu(w_instrHdr.opcode);
        end
        S_IMM: begin
          w_emit = is_known_two_word(r_header.opcode);
          w_imm  = DATA_W'(instruction);
        end
        default: w_emit = 1'b0;
      endcase
    end
    w_valid    = w_emit;
    w_opcode   = w_emit ? w_issueHdr.opcode : '0;
    w_rdst     = w_emit ? w_issueHdr.rdst   : '0;
    w_rs1      = w_emit ? w_issueHdr.rs1    : '0;
    w_rs2      = w_emit ? w_issueHdr.rs2    : '0;
    w_rs1Data  = w_emit ? w_rdData1         : '0;
    w_rs2Data  = w_emit ? w_rdData2         : '0;
    w_pc       = w_emit ? pc_plus_one       : '0;
    w_memRead  = w_emit && mem_read(w_issueHdr.opcode);
    w_regWrite = w_emit && reg_write(w_issueHdr.opcode);
    if (!w_emit) begin
      w_imm = '0;
    end
  end

  // Capture a new header when a two-word instruction starts; flush discards it
  always_comb begin
    w_nextHeader = r_header;
    if (flush) begin
      w_nextHeader = '0;
    end else if (w_startImm) begin
      w_nextHeader = w_instrHdr;
    end
  end

  // Header latch and the ID/EX pipeline register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_header   <= '0;
      r_valid    <= 1'b0;
      r_opcode   <= '0;
      r_rdst     <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rs1Data  <= '0;
      r_rs2Data  <= '0;
      r_imm      <= '0;
      r_pc       <= '0;
      r_memRead  <= 1'b0;
      r_regWrite <= 1'b0;
    end else begin
      r_header   <= w_nextHeader;
      r_valid    <= w_valid;
      r_opcode   <= w_opcode;
      r_rdst     <= w_rdst;
      r_rs1      <= w_rs1;
      r_rs2      <= w_rs2;
      r_rs1Data  <= w_rs1Data;
      r_rs2Data  <= w_rs2Data;
      r_imm      <= w_imm;
      r_pc       <= w_pc;
      r_memRead  <= w_memRead;
      r_regWrite <= w_regWrite;
    end
  end

  assign id_ex_valid       = r_valid;
  assign id_ex_opcode      = r_opcode;
  assign id_ex_rdst        = r_rdst;
  assign id_ex_rs1_addr    = r_rs1;
  assign id_ex_rs2_addr    = r_rs2;
  assign id_ex_rs1_data    = r_rs1Data;
  assign id_ex_rs2_data    = r_rs2Data;
  assign id_ex_imm         = r_imm;
  assign id_ex_pc_plus_one = r_pc;
  assign id_ex_mem_read    = r_memRead;
  assign id_ex_reg_write   = r_regWrite;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a directed vector table, hand-written flush/reset
// sequences around the immediate word, then random traffic against a model.
module tb_decode_stage;

  localparam logic [4:0] OpAlu = 5'b01000;
  localparam logic [4:0] OpLdm = 5'b10000;
  localparam logic [4:0] OpLdd = 5'b10001;
  localparam logic [4:0] OpStd = 5'b10010;
  localparam logic [4:0] OpNop = 5'b00000;

  logic        clk;
  logic        reset;
  logic [15:0] instruction;
  logic [31:0] pcPlusOne;
  logic        flush;
  logic        wbEn;
  logic [2:0]  wbAddr;
  logic [15:0] wbData;
  logic        stallFetch;
  logic        idExValid;
  logic [4:0]  idExOpcode;
  logic [2:0]  idExRdst;
  logic [2:0]  idExRs1Addr;
  logic [2:0]  idExRs2Addr;
  logic [15:0] idExRs1Data;
  logic [15:0] idExRs2Data;
  logic [15:0] idExImm;
  logic [31:0] idExPcPlusOne;
  logic        idExMemRead;
  logic        idExRegWrite;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic        rstN;
    logic        flush;
    logic [15:0] instr;
    logic [31:0] pc;
    logic        wbEn;
    logic [2:0]  wbAddr;
    logic [15:0] wbData;
  } stim_t;

  typedef struct {
    logic        stall;
    logic        valid;
    logic [4:0]  op;
    logic [2:0]  rdst;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [15:0] imm;
    logic [31:0] pc;
    logic        mr;
    logic        rw;
  } obs_t;

  typedef struct {
    stim_t s;
    obs_t  e;
  } vec_t;

  decode_stage dut (
    .clk               (clk),
    .reset             (reset),
    .instruction       (instruction),
    .pc_plus_one       (pcPlusOne),
    .flush             (flush),
    .wb_en             (wbEn),
    .wb_addr           (wbAddr),
    .wb_data           (wbData),
    .stall_fetch       (stallFetch),
    .id_ex_valid       (idExValid),
    .id_ex_opcode      (idExOpcode),
    .id_ex_rdst        (idExRdst),
    .id_ex_rs1_addr    (idExRs1Addr),
    .id_ex_rs2_addr    (idExRs2Addr),
    .id_ex_rs1_data    (idExRs1Data),
    .id_ex_rs2_data    (idExRs2Data),
    .id_ex_imm         (idExImm),
    .id_ex_pc_plus_one (idExPcPlusOne),
    .id_ex_mem_read    (idExMemRead),
    .id_ex_reg_write   (idExRegWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mkInstr(input logic [4:0] op, input logic [2:0] rd,
                                          input logic [2:0] a, input logic [2:0] b);
    return {op, rd, a, b, 2'b00};
  endfunction

  function automatic stim_t mkStim(input logic [15:0] instr, input logic [31:0] pc,
                                   input logic fl, input logic we, input logic [2:0] wa,
                                   input logic [15:0] wd);
    stim_t s;
    s.rstN = 1'b1; s.flush = fl; s.instr = instr; s.pc = pc;
    s.wbEn = we; s.wbAddr = wa; s.wbData = wd;
    return s;
  endfunction

  function automatic obs_t mkOut(input logic st, input logic v, input logic [4:0] op,
                                 input logic [2:0] rd, input logic [2:0] a, input logic [2:0] b,
                                 input logic [15:0] d1, input logic [15:0] d2,
                                 input logic [15:0] imm, input logic [31:0] pc,
                                 input logic mr, input logic rw);
    obs_t o;
    o.stall = st; o.valid = v; o.op = op; o.rdst = rd; o.rs1 = a; o.rs2 = b;
    o.d1 = d1; o.d2 = d2; o.imm = imm; o.pc = pc; o.mr = mr; o.rw = rw;
    return o;
  endfunction

  function automatic obs_t bubble(input logic st);
    return mkOut(st, 1'b0, 5'd0, 3'd0, 3'd0, 3'd0, 16'd0, 16'd0, 16'd0, 32'd0, 1'b0, 1'b0);
  endfunction

  // Reference model: architectural registers, a queue holding a header that
  // still waits for its immediate, and the last result handed to execute
  logic [15:0] mRegs [8];
  logic [15:0] mPending [$];
  obs_t        mLast;

  function automatic logic [15:0] modelRead(input stim_t s, input logic [2:0] a);
    if (s.wbEn && s.wbAddr == a) return s.wbData;
    return mRegs[a];
  endfunction

  task automatic modelStep(input stim_t s, output obs_t o);
    logic [4:0]  op;
    logic [4:0]  hop;
    logic [15:0] hdr;
    logic        isAlu;
    logic        isStd;
    logic        hazard;
    o = bubble(1'b0);
    op = s.instr[15:11];
    if (!s.rstN) begin
      for (int i = 0; i < 8; i++) mRegs[i] = 16'd0;
      mPending.delete();
      mLast = o;
      return;
    end
    if (s.flush) begin
      mPending.delete();
    end else if (mPending.size() != 0) begin
      hdr = mPending.pop_front();
      hop = hdr[15:11];
      if (hop == OpLdm || hop == OpLdd || hop == OpStd) begin
        o = mkOut(1'b0, 1'b1, hop, hdr[10:8], hdr[7:5], hdr[4:2],
                  modelRead(s, hdr[7:5]), modelRead(s, hdr[4:2]), s.instr, s.pc,
                  hop == OpLdd, hop != OpStd);
      end
    end else begin
      isAlu  = (op >= 5'd8) && (op <= 5'd15);
      isStd  = (op == OpStd);
      hazard = mLast.valid && mLast.mr &&
               (((isAlu || isStd) && mLast.rdst == s.instr[7:5]) ||
                (isAlu && mLast.rdst == s.instr[4:2]));
      if (hazard) begin
        o.stall = 1'b1;
      end else if (op >= 5'd16) begin
        mPending.push_back(s.instr);
      end else if (isAlu) begin
        o = mkOut(1'b0, 1'b1, op, s.instr[10:8], s.instr[7:5], s.instr[4:2],
                  modelRead(s, s.instr[7:5]), modelRead(s, s.instr[4:2]), 16'd0, s.pc,
                  1'b0, 1'b1);
      end
    end
    if (s.wbEn) mRegs[s.wbAddr] = s.wbData;
    mLast = o;
  endtask

  // Drive one cycle of inputs, sample the stall before the edge and the
  // registered outputs after it, and advance the model alongside
  task automatic applyStimulus(input stim_t s, output obs_t got, output obs_t mdl);
    @(negedge clk);
    reset = s.rstN; flush = s.flush; instruction = s.instr; pcPlusOne = s.pc;
    wbEn = s.wbEn; wbAddr = s.wbAddr; wbData = s.wbData;
    #1;
    got.stall = stallFetch;
    modelStep(s, mdl);
    @(posedge clk);
    #1;
    got.valid = idExValid;     got.op = idExOpcode;    got.rdst = idExRdst;
    got.rs1 = idExRs1Addr;     got.rs2 = idExRs2Addr;  got.d1 = idExRs1Data;
    got.d2 = idExRs2Data;      got.imm = idExImm;      got.pc = idExPcPlusOne;
    got.mr = idExMemRead;      got.rw = idExRegWrite;
  endtask

  task automatic checkField(input string tag, input string field,
                            input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", tag, field, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input obs_t got, input obs_t exp);
    checkField(tag, "stall_fetch", 32'(got.stall), 32'(exp.stall));
    checkField(tag, "valid",       32'(got.valid), 32'(exp.valid));
    checkField(tag, "opcode",      32'(got.op),    32'(exp.op));
    checkField(tag, "rdst",        32'(got.rdst),  32'(exp.rdst));
    checkField(tag, "rs1_addr",    32'(got.rs1),   32'(exp.rs1));
    checkField(tag, "rs2_addr",    32'(got.rs2),   32'(exp.rs2));
    checkField(tag, "rs1_data",    32'(got.d1),    32'(exp.d1));
    checkField(tag, "rs2_data",    32'(got.d2),    32'(exp.d2));
    checkField(tag, "imm",         32'(got.imm),   32'(exp.imm));
    checkField(tag, "pc_plus_one", got.pc,         exp.pc);
    checkField(tag, "mem_read",    32'(got.mr),    32'(exp.mr));
    checkField(tag, "reg_write",   32'(got.rw),    32'(exp.rw));
  endtask

  // Run a directed step and compare against a hand-derived expectation
  task automatic directed(input string tag, input stim_t s, input obs_t exp);
    obs_t got;
    obs_t mdl;
    applyStimulus(s, got, mdl);
    checkOutput(tag, got, exp);
  endtask

  vec_t  vecs [19];
  stim_t rs;
  stim_t prev;
  obs_t  got;
  obs_t  mdl;
  logic  prevStall;

  initial begin
    reset = 1'b0; flush = 1'b0; instruction = '0; pcPlusOne = '0;
    wbEn = 1'b0; wbAddr = '0; wbData = '0;
    mLast = bubble(1'b0);

    // Reset held two cycles, with a write attempt that must be ignored
    rs = mkStim(mkInstr(OpAlu, 3'd1, 3'd2, 3'd3), 32'h5, 1'b0, 1'b1, 3'd2, 16'h7777);
    rs.rstN = 1'b0;
    directed("reset0", rs, bubble(1'b0));
    directed("reset1", rs, bubble(1'b0));

    vecs[0]  = '{mkStim(mkInstr(OpAlu,3'd0,3'd0,3'd1), 32'h10, 0, 0, 0, 0),
                 mkOut(0,1,OpAlu,3'd0,3'd0,3'd1,16'h0,16'h0,16'h0,32'h10,0,1)};
    vecs[1]  = '{mkStim(mkInstr(OpAlu,3'd0,3'd2,3'd3), 32'h11, 0, 0, 0, 0),
                 mkOut(0,1,OpAlu,3'd0,3'd2,3'd3,16'h0,16'h0,16'h0,32'h11,0,1)};
    vecs[2]  = '{mkStim(mkInstr(OpAlu,3'd0,3'd4,3'd5), 32'h12, 0, 0, 0, 0),
                 mkOut(0,1,OpAlu,3'd0,3'd4,3'd5,16'h0,16'h0,16'h0,32'h12,0,1)};
    vecs[3]  = '{mkStim(mkInstr(OpAlu,3'd0,3'd6,3'd7), 32'h13, 0, 0, 0, 0),
                 mkOut(0,1,OpAlu,3'd0,3'd6,3'd7,16'h0,16'h0,16'h0,32'h13,0,1)};
    vecs[4]  = '{mkStim(mkInstr(OpNop,3'd0,3'd0,3'd0), 32'h14, 0, 1, 3'd2, 16'h0005), bubble(0)};
    vecs[5]  = '{mkStim(mkInstr(OpNop,3'd0,3'd0,3'd0), 32'h15, 0, 1, 3'd3, 16'h0003), bubble(0)};
    vecs[6]  = '{mkStim(mkInstr(OpAlu,3'd1,3'd2,3'd3), 32'h16, 0, 0, 0, 0),
                 mkOut(0,1,OpAlu,3'd1,3'd2,3'd3,16'h5,16'h3,16'h0,32'h16,0,1)};
    vecs[7]  = '{mkStim(mkInstr(OpAlu,3'd0,3'd4,3'd3), 32'h17, 0, 1, 3'd4, 16'hBEEF),
                 mkOut(0,1,OpAlu,3'd0,3'd4,3'd3,16'hBEEF,16'h3,16'h0,32'h17,0,1)};
    vecs[8]  = '{mkStim(mkInstr(OpLdm,3'd5,3'd0,3'd0), 32'h20, 0, 0, 0, 0), bubble(0)};
    vecs[9]  = '{mkStim(16'h1234, 32'h21, 0, 0, 0, 0),
                 mkOut(0,1,OpLdm,3'd5,3'd0,3'd0,16'h0,16'h0,16'h1234,32'h21,0,1)};
    vecs[10] = '{mkStim(mkInstr(OpLdd,3'd2,3'd0,3'd0), 32'h2F, 0, 0, 0, 0), bubble(0)};
    vecs[11] = '{mkStim(16'h0040, 32'h30, 0, 0, 0, 0),
                 mkOut(0,1,OpLdd,3'd2,3'd0,3'd0,16'h0,16'h0,16'h0040,32'h30,1,1)};
    vecs[12] = '{mkStim(mkInstr(OpAlu,3'd6,3'd2,3'd7), 32'h31, 0, 0, 0, 0), bubble(1)};
    vecs[13] = '{mkStim(mkInstr(OpAlu,3'd6,3'd2,3'd7), 32'h31, 0, 0, 0, 0),
                 mkOut(0,1,OpAlu,3'd6,3'd2,3'd7,16'h5,16'h0,16'h0,32'h31,0,1)};
    vecs[14] = '{mkStim(mkInstr(OpLdd,3'd3,3'd0,3'd0), 32'h32, 0, 0, 0, 0), bubble(0)};
    vecs[15] = '{mkStim(16'h0050, 32'h33, 0, 0, 0, 0),
                 mkOut(0,1,OpLdd,3'd3,3'd0,3'd0,16'h0,16'h0,16'h0050,32'h33,1,1)};
    vecs[16] = '{mkStim(mkInstr(OpStd,3'd0,3'd3,3'd0), 32'h34, 0, 0, 0, 0), bubble(1)};
    vecs[17] = '{mkStim(mkInstr(OpStd,3'd0,3'd3,3'd0), 32'h34, 0, 0, 0, 0), bubble(0)};
    vecs[18] = '{mkStim(16'h0060, 32'h35, 0, 0, 0, 0),
                 mkOut(0,1,OpStd,3'd0,3'd3,3'd0,16'h3,16'h0,16'h0060,32'h35,0,0)};

    for (int i = 0; i < 19; i++) begin
      directed($sformatf("vec%0d", i), vecs[i].s, vecs[i].e);
    end

    // Flush while the immediate is on the bus; the immediate looks like an LDM header
    directed("flushImm.hdr", mkStim(mkInstr(OpLdm,3'd1,3'd0,3'd0), 32'h4F, 0, 0, 0, 0), bubble(0));
    directed("flushImm.imm", mkStim(16'h8000, 32'h50, 1, 0, 0, 0), bubble(0));
    directed("flushImm.next", mkStim(mkInstr(OpAlu,3'd7,3'd2,3'd3), 32'h52, 0, 0, 0, 0),
             mkOut(0,1,OpAlu,3'd7,3'd2,3'd3,16'h5,16'h3,16'h0,32'h52,0,1));

    // Flush coinciding with a load-use stall, then an rs2-only dependency
    directed("flushStall.hdr", mkStim(mkInstr(OpLdd,3'd2,3'd0,3'd0), 32'h60, 0, 0, 0, 0), bubble(0));
    directed("flushStall.imm", mkStim(16'h0070, 32'h61, 0, 0, 0, 0),
             mkOut(0,1,OpLdd,3'd2,3'd0,3'd0,16'h0,16'h0,16'h0070,32'h61,1,1));
    directed("flushStall.both", mkStim(mkInstr(OpAlu,3'd1,3'd2,3'd2), 32'h62, 1, 0, 0, 0), bubble(0));
    directed("flushStall.after", mkStim(mkInstr(OpAlu,3'd1,3'd2,3'd2), 32'h62, 0, 0, 0, 0),
             mkOut(0,1,OpAlu,3'd1,3'd2,3'd2,16'h5,16'h5,16'h0,32'h62,0,1));
    directed("rs2Use.hdr", mkStim(mkInstr(OpLdd,3'd6,3'd0,3'd0), 32'h70, 0, 0, 0, 0), bubble(0));
    directed("rs2Use.imm", mkStim(16'h0080, 32'h71, 0, 0, 0, 0),
             mkOut(0,1,OpLdd,3'd6,3'd0,3'd0,16'h0,16'h0,16'h0080,32'h71,1,1));
    directed("rs2Use.stall", mkStim(mkInstr(OpAlu,3'd0,3'd1,3'd6), 32'h72, 0, 0, 0, 0), bubble(1));
    directed("rs2Use.issue", mkStim(mkInstr(OpAlu,3'd0,3'd1,3'd6), 32'h72, 0, 0, 0, 0),
             mkOut(0,1,OpAlu,3'd0,3'd1,3'd6,16'h0,16'h0,16'h0,32'h72,0,1));

    // Reset in the middle of an immediate: registers cleared, write suppressed
    directed("resetImm.hdr", mkStim(mkInstr(OpLdm,3'd3,3'd0,3'd0), 32'h80, 0, 0, 0, 0), bubble(0));
    rs = mkStim(16'h8800, 32'h81, 0, 1, 3'd5, 16'hAAAA);
    rs.rstN = 1'b0;
    directed("resetImm.rst", rs, bubble(0));
    directed("resetImm.next", mkStim(mkInstr(OpAlu,3'd1,3'd2,3'd5), 32'h91, 0, 0, 0, 0),
             mkOut(0,1,OpAlu,3'd1,3'd2,3'd5,16'h0,16'h0,16'h0,32'h91,0,1));

    // Random traffic; fetch re-presents the same word whenever it was stalled
    prevStall = 1'b0;
    prev = mkStim(16'h0, 32'h0, 0, 0, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      rs.rstN   = ($urandom_range(0, 99) != 0);
      rs.flush  = ($urandom_range(0, 9) == 0);
      rs.wbEn   = $urandom_range(0, 1) == 1;
      rs.wbAddr = 3'($urandom_range(0, 7));
      rs.wbData = 16'($urandom);
      rs.pc     = $urandom;
      case (kind)
        0, 1, 2, 3: rs.instr = mkInstr({2'b01, 3'($urandom_range(0, 7))}, 3'($urandom_range(0, 3)),
                                       3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)));
        4:       rs.instr = mkInstr(OpLdd, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'd0);
        5:       rs.instr = mkInstr(OpLdm, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'd1);
        6:       rs.instr = mkInstr(OpStd, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                                    3'($urandom_range(0, 3)));
        7:       rs.instr = 16'h0000;
        default: rs.instr = 16'($urandom);
      endcase
      if (prevStall) begin
        rs.instr = prev.instr;
        rs.pc    = prev.pc;
      end
      applyStimulus(rs, got, mdl);
      checkOutput($sformatf("rand%0d", n), got, mdl);
      prevStall = mdl.stall;
      prev = rs;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
